// File: rtl/ibex_mult_pext_sequencer.sv
// Phase sequencer for the packed-SIMD multiplier array: walks LO/HI/ACC, holds the intermediate product, accumulates.
// Define IBEX_PEXT_MULT_SAT_EN to saturate accumulate results (ov_o flags a clamp); otherwise they wrap.
module ibex_mult_pext_sequencer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mult_en_i,
    input  logic        kill_i,
    input  logic [1:0]  mult_mode_i,
    input  logic [1:0]  cycle_count_i,
    input  logic [1:0]  accum_sub_i,
    input  logic        crossed_i,
    input  logic [31:0] op_b_i,
    input  logic [31:0] op_c_i,
    input  logic [31:0] mult_prod_i,
    output logic [31:0] mult_op_b_o,
    output logic [1:0]  phase_o,
    output logic        array_sub_o,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        busy_o,
    output logic        ov_o
);

    typedef enum logic [1:0] {M8x8, M16x16, M32x16, M32x32} mult_pext_mode_e;
    typedef enum logic [1:0] {IDLE, HI, ACC} seq_state_e;

    localparam logic [1:0] PH_LO  = 2'd0;
    localparam logic [1:0] PH_HI  = 2'd1;
    localparam logic [1:0] PH_ACC = 2'd2;

    seq_state_e  state_q, state_d;
    logic [31:0] imd_q, imd_d;
    logic        final_cyc;
    logic        use_acc;
    logic        abort;
    logic [31:0] acc_res;

    // Once an op is underway, losing the request is handled exactly like a kill.
    assign abort = kill_i | ~mult_en_i;

    always_comb begin
        state_d   = state_q;
        imd_d     = imd_q;
        phase_o   = PH_LO;
        final_cyc = 1'b0;
        use_acc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mult_en_i) begin
                    if (kill_i) begin
                        imd_d = '0;
                    end else begin
                        unique case (cycle_count_i)
                            2'b00: final_cyc = 1'b1;
                            2'b10: begin
                                imd_d   = mult_prod_i;
                                state_d = ACC;
                            end
                            default: begin
                                imd_d   = mult_prod_i;
                                state_d = HI;
                            end
                        endcase
                    end
                end
            end
            HI: begin
                phase_o = PH_HI;
                if (abort) begin
                    state_d = IDLE;
                    imd_d   = '0;
                end else if (cycle_count_i == 2'b11) begin
                    imd_d   = mult_prod_i;
                    state_d = ACC;
                end else begin
                    final_cyc = 1'b1;
                    state_d   = IDLE;
                end
            end
            ACC: begin
                phase_o = PH_ACC;
                use_acc = 1'b1;
                state_d = IDLE;
                if (abort) begin
                    imd_d = '0;
                end else begin
                    final_cyc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                imd_d   = '0;
            end
        endcase
        // Nothing survives a finished op; the next op always recaptures.
        if (final_cyc) begin
            imd_d = '0;
        end
    end

`ifdef IBEX_PEXT_MULT_SAT_EN
    logic signed [32:0] acc_sum;
    logic               acc_ovf;

    assign acc_sum = accum_sub_i[1] ? ($signed({op_c_i[31], op_c_i}) - $signed({imd_q[31], imd_q}))
                                    : ($signed({op_c_i[31], op_c_i}) + $signed({imd_q[31], imd_q}));
    // Overflow iff the two top bits of the 33-bit result disagree; bit 32 is the true sign.
    assign acc_ovf = acc_sum[32] ^ acc_sum[31];
    assign acc_res = acc_ovf ? (acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_sum[31:0];
    assign ov_o    = valid_o & use_acc & acc_ovf;
`else
    // Wrapping result equals the low 32 bits of the sign-extended 33-bit sum.
    assign acc_res = accum_sub_i[1] ? (op_c_i - imd_q) : (op_c_i + imd_q);
    assign ov_o    = 1'b0;
`endif

    assign valid_o     = final_cyc;
    assign result_o    = final_cyc ? (use_acc ? acc_res : mult_prod_i) : '0;
    assign busy_o      = (state_q != IDLE);
    assign array_sub_o = accum_sub_i[0];
    assign mult_op_b_o = (crossed_i && (mult_pext_mode_e'(mult_mode_i) != M32x32))
                         ? {op_b_i[15:0], op_b_i[31:16]} : op_b_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            imd_q   <= '0;
        end else begin
            state_q <= state_d;
            imd_q   <= imd_d;
        end
    end

endmodule

// File: tb/tb_ibex_mult_pext_sequencer.sv
// Bench for ibex_mult_pext_sequencer: directed table, multi-cycle corner sequences, random ops vs a reference model.
module tb_ibex_mult_pext_sequencer;

    localparam bit SAT =
`ifdef IBEX_PEXT_MULT_SAT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mult_en_i = 1'b0;
    logic        kill_i = 1'b0;
    logic [1:0]  mult_mode_i = 2'd0;
    logic [1:0]  cycle_count_i = 2'd0;
    logic [1:0]  accum_sub_i = 2'd0;
    logic        crossed_i = 1'b0;
    logic [31:0] op_b_i = '0;
    logic [31:0] op_c_i = '0;
    logic [31:0] mult_prod_i = '0;
    logic [31:0] mult_op_b_o;
    logic [1:0]  phase_o;
    logic        array_sub_o;
    logic [31:0] result_o;
    logic        valid_o;
    logic        busy_o;
    logic        ov_o;

    int n_chk = 0;
    int n_fail = 0;

    ibex_mult_pext_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mult_en_i(mult_en_i), .kill_i(kill_i),
        .mult_mode_i(mult_mode_i), .cycle_count_i(cycle_count_i), .accum_sub_i(accum_sub_i),
        .crossed_i(crossed_i), .op_b_i(op_b_i), .op_c_i(op_c_i), .mult_prod_i(mult_prod_i),
        .mult_op_b_o(mult_op_b_o), .phase_o(phase_o), .array_sub_o(array_sub_o),
        .result_o(result_o), .valid_o(valid_o), .busy_o(busy_o), .ov_o(ov_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  cc;
        logic [1:0]  asub;
        logic [31:0] opc;
        logic [31:0] p0, p1, p2;
        logic [31:0] eres;
        logic        eov;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        mult_en_i = 1'b0;
        kill_i    = 1'b0;
        step();
    endtask

    // Reference: schedule list from the op code; ACC works on the last product captured before it.
    function automatic void ref_model(input logic [1:0] cc, input logic [1:0] asub, input logic [31:0] opc,
                                      input logic [31:0] p0, input logic [31:0] p1,
                                      output logic [31:0] res, output logic ov);
        longint a, b, v;
        logic [31:0] imd;
        ov = 1'b0;
        if (cc[1]) begin
            imd = (cc == 2'b11) ? p1 : p0;
            a = longint'($signed(opc));
            b = longint'($signed(imd));
            v = asub[1] ? (a - b) : (a + b);
            if (SAT && v > 64'sd2147483647) begin
                res = 32'h7FFF_FFFF;
                ov  = 1'b1;
            end else if (SAT && v < -64'sd2147483648) begin
                res = 32'h8000_0000;
                ov  = 1'b1;
            end else begin
                res = v[31:0];
            end
        end else begin
            res = (cc == 2'b01) ? p1 : p0;
        end
    endfunction

    // Runs one op starting now; leaves mult_en_i high so a following call is back-to-back.
    task automatic run_op(input logic [1:0] cc, input logic [1:0] asub, input logic [31:0] opc,
                          input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                          input logic [31:0] eres, input logic eov, input string tag);
        logic [31:0] pv[3];
        logic [1:0]  sched[$];
        pv[0] = p0; pv[1] = p1; pv[2] = p2;
        sched.delete();
        sched.push_back(2'd0);
        if (cc[0]) sched.push_back(2'd1);
        if (cc[1]) sched.push_back(2'd2);
        cycle_count_i = cc;
        accum_sub_i   = asub;
        op_c_i        = opc;
        kill_i        = 1'b0;
        mult_en_i     = 1'b1;
        for (int k = 0; k < sched.size(); k++) begin
            mult_prod_i = pv[k];
            @(negedge clk_i);
            chk({tag, " phase"}, 32'(phase_o), 32'(sched[k]));
            chk({tag, " busy"}, 32'(busy_o), (k > 0) ? 32'd1 : 32'd0);
            chk({tag, " array_sub"}, 32'(array_sub_o), 32'(asub[0]));
            if (k < sched.size() - 1) begin
                chk({tag, " early valid"}, 32'(valid_o), 32'd0);
            end else begin
                chk({tag, " valid"}, 32'(valid_o), 32'd1);
                chk({tag, " result"}, result_o, eres);
                chk({tag, " ov"}, 32'(ov_o), 32'(eov));
            end
            step();
        end
    endtask

    initial begin
        logic [31:0] er, ob, eob;
        logic        eo;
        logic [1:0]  cc, asub;
        logic [31:0] opc, p0, p1, p2;

        tbl[0] = '{2'b00, 2'b00, 32'h0, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234, 1'b0};
        tbl[1] = '{2'b11, 2'b00, 32'h7FFF_FFF0, 32'h1, 32'h20, 32'hDEAD_BEEF,
                   SAT ? 32'h7FFF_FFFF : 32'h8000_0010, SAT};
        tbl[2] = '{2'b10, 2'b10, 32'h5, 32'h7, 32'h1357_9BDF, 32'h0, 32'hFFFF_FFFE, 1'b0};
        tbl[3] = '{2'b01, 2'b01, 32'h0, 32'h11, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 1'b0};
        tbl[4] = '{2'b10, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h2468_ACE0, 32'h0,
                   SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, SAT};
        tbl[5] = '{2'b11, 2'b10, 32'h10, 32'h5, 32'h3, 32'hFFFF_0000, 32'hD, 1'b0};
        tbl[6] = '{2'b10, 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0,
                   SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT};

        // Reset state, with a request pending to show reset dominates.
        mult_en_i = 1'b1;
        mult_prod_i = 32'h1111_1111;
        @(negedge clk_i);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset phase", 32'(phase_o), 32'd0);
        mult_en_i = 1'b0;
        #1;
        chk("reset valid", 32'(valid_o), 32'd0);
        chk("reset result", result_o, 32'd0);
        chk("reset ov", 32'(ov_o), 32'd0);
        step();
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].cc, tbl[i].asub, tbl[i].opc, tbl[i].p0, tbl[i].p1, tbl[i].p2,
                   tbl[i].eres, tbl[i].eov, $sformatf("tbl%0d", i));
            idle_cycle();
            #1;
            chk($sformatf("tbl%0d idle busy", i), 32'(busy_o), 32'd0);
            chk($sformatf("tbl%0d idle result", i), result_o, 32'd0);
        end

        // Operand B routing.
        for (int i = 0; i < 16; i++) begin
            ob = (i < 8) ? 32'hAAAA_5555 : $urandom;
            mult_mode_i = 2'(i % 4);
            crossed_i   = 1'((i / 4) % 2);
            #1;
            eob = (crossed_i && mult_mode_i != 2'd3) ? {ob[15:0], ob[31:16]} : ob;
            op_b_i = ob;
            #1;
            chk($sformatf("op_b mode%0d x%0d", mult_mode_i, crossed_i), mult_op_b_o, eob);
        end
        crossed_i = 1'b0;

        // Kill in HI: no completion, back to IDLE with the intermediate cleared.
        cycle_count_i = 2'b11; op_c_i = 32'h100; mult_en_i = 1'b1; mult_prod_i = 32'h1234;
        step();
        kill_i = 1'b1; mult_prod_i = 32'h5678;
        @(negedge clk_i);
        chk("kill phase", 32'(phase_o), 32'd1);
        chk("kill valid", 32'(valid_o), 32'd0);
        chk("kill result", result_o, 32'd0);
        step();
        kill_i = 1'b0; mult_en_i = 1'b0;
        chk("kill busy after", 32'(busy_o), 32'd0);
        chk("kill imd cleared", dut.imd_q, 32'd0);
        run_op(2'b00, 2'b00, 32'h0, 32'h55, 32'h0, 32'h0, 32'h55, 1'b0, "post-kill");
        idle_cycle();

        // Request dropped in ACC acts as a kill.
        cycle_count_i = 2'b10; op_c_i = 32'h1; mult_en_i = 1'b1; mult_prod_i = 32'h2;
        step();
        mult_en_i = 1'b0;
        @(negedge clk_i);
        chk("drop valid", 32'(valid_o), 32'd0);
        chk("drop ov", 32'(ov_o), 32'd0);
        step();
        chk("drop busy after", 32'(busy_o), 32'd0);

        // Back-to-back cc=01, reset pulse spanning the end of cycle 3.
        run_op(2'b01, 2'b00, 32'h0, 32'hA, 32'hB, 32'h0, 32'hB, 1'b0, "b2b op1");
        mult_prod_i = 32'hC;
        @(negedge clk_i);
        chk("b2b op2 LO valid", 32'(valid_o), 32'd0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        mult_prod_i = 32'hD;
        @(negedge clk_i);
        chk("b2b cycle4 valid", 32'(valid_o), 32'd0);
        chk("b2b cycle4 phase", 32'(phase_o), 32'd0);
        chk("b2b cycle4 busy", 32'(busy_o), 32'd0);
        idle_cycle();

        // Immediate async reset in the middle of HI.
        cycle_count_i = 2'b11; mult_en_i = 1'b1; mult_prod_i = 32'h9;
        step();
        @(negedge clk_i);
        chk("mid busy before rst", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid busy in rst", 32'(busy_o), 32'd0);
        chk("mid phase in rst", 32'(phase_o), 32'd0);
        mult_en_i = 1'b0;
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("post-rst valid", 32'(valid_o), 32'd0);
            step();
        end

        // Random ops against the reference model, random gaps or back-to-back.
        for (int i = 0; i < 60; i++) begin
            cc   = 2'($urandom_range(0, 3));
            asub = 2'($urandom_range(0, 3));
            opc  = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) != 0 ? 32'h7FFF_FF00 : 32'h8000_0000)
                                                  + 32'($urandom_range(0, 255))) : $urandom;
            p0   = $urandom;
            p1   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 1023));
            p2   = $urandom;
            ref_model(cc, asub, opc, p0, p1, er, eo);
            run_op(cc, asub, opc, p0, p1, p2, er, eo, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) != 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
